// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive blocks:
//   - clks_per_bit(): rounded clock-cycles-per-bit divider
//   - uart_state_e:   bit-level framing states (IDLE, START, DATA, STOP)
//   - DATA_BITS / STOP_BITS: 8N1 frame constants
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // round(clk_freq / baud), computed in 64 bits so the half-baud rounding
  // term cannot overflow for large clock frequencies.
  function automatic int clks_per_bit(input int unsigned clk_freq,
                                      input int unsigned baud);
    longint unsigned f;
    longint unsigned b;
    f = longint'(clk_freq);
    b = longint'(baud);
    return int'((f + b / 2) / b);
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Frames a single byte as 8N1 (start, 8 data bits LSB first, stop).
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   valid_i  byte offered on data_i
//   data_i   byte to frame, captured when valid_i && ready_o
//   ready_o  high when a byte can be taken this cycle: while idle, or in the
//            final cycle of a stop bit so the next start bit follows with no gap
//   tx_o     registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_e       state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        data_q;
  logic              tx_q;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign ready_o   = (state_q == IDLE) || ((state_q == STOP) && baud_last);
  assign tx_o      = tx_q;

  // The baud counter restarts from zero on every state or bit transition,
  // so each bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (valid_i) begin
            data_q  <= data_i;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // data_q[0] always holds the bit on the line; shift to expose the next.
              bit_q  <= bit_q + 3'd1;
              tx_q   <= data_q[1];
              data_q <= {1'b0, data_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (valid_i) begin
              data_q  <= data_i;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/digest_uart_tx.sv
// -----------------------------------------------------------------------------
// digest_uart_tx
// Sends a NUM_BYTES-wide result word over an 8N1 UART, most-significant byte
// first, with no idle gap between bytes.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   data_in  word to send, sampled only in the accept cycle
//   send     start request, accepted when busy is low
//   TxD      serial line, idle high (registered)
//   busy     high from the cycle after accept until the message completes
//   done     one-cycle pulse after the final stop bit (registered)
// -----------------------------------------------------------------------------
module digest_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned NUM_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BYTES*8-1:0] data_in,
  input  logic                   send,
  output logic                   TxD,
  output logic                   busy,
  output logic                   done
);

  localparam int DATA_W = NUM_BYTES * 8;
  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  if (CPB < 2) begin : g_cpb_check
    $error("digest_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  logic [DATA_W-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, last_byte;
  logic              byte_valid, byte_ready;
  logic [7:0]        byte_data;

  assign accept    = send && !busy_q;
  assign last_byte = (byte_cnt_q == CNT_W'(NUM_BYTES - 1));
  assign shifted   = shift_q << 8;

  // The byte framer hands over the next byte on the same edge that ends the
  // previous stop bit, so the following byte comes from the post-shift word.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_valid = 1'b0;
    byte_data  = shifted[DATA_W-1 -: 8];
    if (accept) begin
      shift_d    = data_in;
      byte_cnt_d = '0;
      busy_d     = 1'b1;
      byte_valid = 1'b1;
      byte_data  = data_in[DATA_W-1 -: 8];
    end else if (busy_q && byte_ready) begin
      if (last_byte) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        byte_valid = 1'b1;
        shift_d    = shifted;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CPB)
  ) u_byte_tx (
    .clk    (clk),
    .rst    (rst),
    .valid_i(byte_valid),
    .data_i (byte_data),
    .ready_o(byte_ready),
    .tx_o   (TxD)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_digest_uart_tx.sv
module tb_digest_uart_tx;

  localparam int unsigned CLK_F  = 1_000_000;
  localparam int unsigned BAUD_R = 250_000;
  localparam int          CPB    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, send2, tx2, busy2, done2;
  logic [15:0] data2;
  logic        rst32, send32, tx32, busy32, done32;
  logic [255:0] data32;

  digest_uart_tx #(.CLK_FREQ(CLK_F), .BAUD(BAUD_R), .NUM_BYTES(2)) dut2 (
    .clk(clk), .rst(rst2), .data_in(data2), .send(send2),
    .TxD(tx2), .busy(busy2), .done(done2)
  );

  digest_uart_tx #(.CLK_FREQ(CLK_F), .BAUD(BAUD_R), .NUM_BYTES(32)) dut32 (
    .clk(clk), .rst(rst32), .data_in(data32), .send(send32),
    .TxD(tx32), .busy(busy32), .done(done32)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic rec_tx[$];
  logic rec_busy[$];
  logic rec_done[$];
  bit   sel32 = 1'b0;

  // Record the selected DUT's outputs once per cycle; entry i is cycle (first + i).
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      rec_tx.push_back(sel32 ? tx32 : tx2);
      rec_busy.push_back(sel32 ? busy32 : busy2);
      rec_done.push_back(sel32 ? done32 : done2);
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_rec();
    rec_tx.delete();
    rec_busy.delete();
    rec_done.delete();
  endtask

  // Line level for position pos (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Expected line for a two-byte message at offset o (1-based) after accept.
  function automatic logic line_model(input logic [15:0] w, input int o);
    int bi;
    logic [7:0] b;
    if (o < 1 || o > 20 * CPB) return 1'b1;
    bi = (o - 1) / CPB;
    b  = (bi < 10) ? w[15:8] : w[7:0];
    return frame_bit(b, bi % 10);
  endfunction

  // UART receiver model: sample mid-bit of a frame whose start bit begins at cycle s
  // (record index = cycle - 1).
  function automatic logic [7:0] decode_byte(input int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = rec_tx[s + CPB * (1 + k) + CPB / 2 - 1];
    return b;
  endfunction

  task automatic test_reset();
    rst2 = 1'b1; rst32 = 1'b1; send2 = 1'b1; send32 = 1'b1;
    data2 = 16'hBEEF; data32 = {8{32'hDEADBEEF}};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx2, busy2, done2, tx32, busy32, done32} !== 6'b100_100) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got tx/busy/done %b%b%b %b%b%b want 100 100",
                 i, tx2, busy2, done2, tx32, busy32, done32);
      end
    end
    rst2 = 1'b0; rst32 = 1'b0; send2 = 1'b0; send32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx2, busy2, done2, tx32, busy32, done32} !== 6'b100_100) begin
        errors++;
        $display("FAIL reset_release cycle %0d got tx/busy/done %b%b%b %b%b%b want 100 100",
                 i, tx2, busy2, done2, tx32, busy32, done32);
      end
    end
  endtask

  task automatic test_two_byte();
    logic etx, ebusy, edone;
    logic [7:0] got, want;
    clear_rec(); sel32 = 1'b0;
    data2 = 16'hA55A; send2 = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    @(posedge clk); #1; send2 = 1'b0; data2 = 16'h0000;
    capture(84);
    for (int c = 1; c <= 84; c++) begin
      etx = line_model(16'hA55A, c); ebusy = (c <= 80); edone = (c == 81);
      checks++;
      if ({rec_tx[c-1], rec_busy[c-1], rec_done[c-1]} !== {etx, ebusy, edone}) begin
        errors++;
        $display("FAIL two_byte cycle %0d got tx/busy/done %b%b%b want %b%b%b",
                 c, rec_tx[c-1], rec_busy[c-1], rec_done[c-1], etx, ebusy, edone);
      end
    end
    for (int j = 0; j < 2; j++) begin
      got = decode_byte(1 + j * 10 * CPB); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL two_byte_rx byte %0d got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_send_while_busy();
    logic etx, ebusy, edone;
    logic [7:0] got, want;
    clear_rec(); sel32 = 1'b0;
    data2 = 16'hA55A; send2 = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    @(posedge clk); #1; send2 = 1'b0;
    fork
      capture(90);
      begin
        repeat (19) @(posedge clk); #1;
        data2 = 16'hFFFF; send2 = 1'b1;
        @(posedge clk); #1; send2 = 1'b0;
      end
    join
    for (int c = 1; c <= 90; c++) begin
      etx = line_model(16'hA55A, c); ebusy = (c <= 80); edone = (c == 81);
      checks++;
      if ({rec_tx[c-1], rec_busy[c-1], rec_done[c-1]} !== {etx, ebusy, edone}) begin
        errors++;
        $display("FAIL busy_send cycle %0d got tx/busy/done %b%b%b want %b%b%b",
                 c, rec_tx[c-1], rec_busy[c-1], rec_done[c-1], etx, ebusy, edone);
      end
    end
    for (int j = 0; j < 2; j++) begin
      got = decode_byte(1 + j * 10 * CPB); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL busy_send_rx byte %0d got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic etx, ebusy, edone;
    logic [7:0] got, want;
    clear_rec(); sel32 = 1'b0;
    data2 = 16'hA55A; send2 = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    @(posedge clk); #1; send2 = 1'b0;
    fork
      capture(130);
      begin
        repeat (29) @(posedge clk); #1;
        rst2 = 1'b1; exp_q.delete();
        @(posedge clk); #1; rst2 = 1'b0;
        repeat (9) @(posedge clk); #1;
        data2 = 16'hC33C; send2 = 1'b1;
        exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        @(posedge clk); #1; send2 = 1'b0;
      end
    join
    for (int c = 1; c <= 130; c++) begin
      if (c <= 30) begin
        etx = line_model(16'hA55A, c); ebusy = 1'b1;
      end else if (c <= 40) begin
        etx = 1'b1; ebusy = 1'b0;
      end else begin
        etx = line_model(16'hC33C, c - 40); ebusy = (c <= 120);
      end
      edone = (c == 121);
      checks++;
      if ({rec_tx[c-1], rec_busy[c-1], rec_done[c-1]} !== {etx, ebusy, edone}) begin
        errors++;
        $display("FAIL mid_reset cycle %0d got tx/busy/done %b%b%b want %b%b%b",
                 c, rec_tx[c-1], rec_busy[c-1], rec_done[c-1], etx, ebusy, edone);
      end
    end
    for (int j = 0; j < 2; j++) begin
      got = decode_byte(41 + j * 10 * CPB); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mid_reset_rx byte %0d got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic etx, ebusy, edone;
    logic [7:0] got, want;
    int n;
    bit seen;
    clear_rec(); sel32 = 1'b0;
    data2 = 16'hA55A; send2 = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    @(posedge clk); #1; send2 = 1'b0;
    n = 0; seen = 1'b0;
    fork
      capture(170);
      begin
        while (!seen && n < 120) begin
          if (done2 === 1'b1) seen = 1'b1;
          else begin @(posedge clk); #1; n++; end
        end
        if (seen) begin
          data2 = 16'h1234; send2 = 1'b1;
          exp_q.push_back(8'h12); exp_q.push_back(8'h34);
          @(posedge clk); #1; send2 = 1'b0;
        end
      end
    join
    checks++;
    if (!seen || (n + 1) != 81) begin
      errors++;
      $display("FAIL b2b_done_cycle got seen=%0d cycle %0d want cycle 81", seen, n + 1);
    end
    for (int c = 1; c <= 170; c++) begin
      if (c <= 81) etx = line_model(16'hA55A, c);
      else         etx = line_model(16'h1234, c - 81);
      ebusy = (c <= 80) || (c >= 82 && c <= 161);
      edone = (c == 81) || (c == 162);
      checks++;
      if ({rec_tx[c-1], rec_busy[c-1], rec_done[c-1]} !== {etx, ebusy, edone}) begin
        errors++;
        $display("FAIL b2b cycle %0d got tx/busy/done %b%b%b want %b%b%b",
                 c, rec_tx[c-1], rec_busy[c-1], rec_done[c-1], etx, ebusy, edone);
      end
    end
    for (int j = 0; j < 4; j++) begin
      got = decode_byte((j < 2 ? 1 : 82) + (j % 2) * 10 * CPB);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_rx byte %0d got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_full_message();
    logic etx, ebusy, edone;
    logic [7:0] got, want;
    int bi;
    clear_rec(); sel32 = 1'b1;
    for (int j = 0; j < 32; j++) begin
      data32[255 - 8 * j -: 8] = 8'(j);
      exp_q.push_back(8'(j));
    end
    send32 = 1'b1;
    @(posedge clk); #1; send32 = 1'b0; data32 = '1;
    capture(1290);
    for (int c = 1; c <= 1290; c++) begin
      bi = (c - 1) / CPB;
      etx   = (c <= 1280) ? frame_bit(8'(bi / 10), bi % 10) : 1'b1;
      ebusy = (c <= 1280);
      edone = (c == 1281);
      checks++;
      if ({rec_tx[c-1], rec_busy[c-1], rec_done[c-1]} !== {etx, ebusy, edone}) begin
        errors++;
        $display("FAIL full32 cycle %0d got tx/busy/done %b%b%b want %b%b%b",
                 c, rec_tx[c-1], rec_busy[c-1], rec_done[c-1], etx, ebusy, edone);
      end
    end
    for (int j = 0; j < 32; j++) begin
      got = decode_byte(1 + j * 10 * CPB); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL full32_rx byte %0d got %h want %h", j, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    repeat (5) @(posedge clk); #1;
    test_send_while_busy();
    repeat (5) @(posedge clk); #1;
    test_reset_mid_frame();
    repeat (5) @(posedge clk); #1;
    test_back_to_back();
    repeat (5) @(posedge clk); #1;
    test_full_message();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digest_uart_tx.md
# digest_uart_tx

Serializes a wide result word (default 256-bit SHA-256 digest) from the hash core back to the host over an 8N1 UART line, most-significant byte first. It is the transmit-side counterpart of the 608-bit message receiver: the receiver feeds the hash core, and this block returns the core's result. It latches the whole word on a start pulse and frames every byte with its own internal baud timing.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- NUM_BYTES, 32: bytes sent per message. DATA_W = NUM_BYTES*8 is a derived constant, not overridable.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  DATA_W  word to transmit. Sampled only in the accept cycle.
- send  in  1  start request. Accepted only when busy=0.
- TxD  out  1  serial line, idle high.
- busy  out  1  high from the cycle after accept until the message completes.
- done  out  1  one-cycle pulse when the final stop bit has finished.

## Operation
- CLKS_PER_BIT = round(CLK_FREQ/BAUD), which is 868 at the defaults. An elaboration error is required if CLKS_PER_BIT < 2.
- States:
  - IDLE: TxD=1. Accept event is send=1 with busy=0. On accept, latch data_in into a DATA_W shift register, set byte_cnt=0, go to START.
  - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: TxD = current byte bit[bit_cnt], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles.
    - If byte_cnt = NUM_BYTES-1: go to IDLE and pulse done.
    - Otherwise: shift the register left 8, increment byte_cnt, go directly to START. There is no inter-byte idle gap.
- Current byte is shift_reg[DATA_W-1 -: 8]. Byte 0 is data_in[DATA_W-1:DATA_W-8], the same byte order the receiver uses.
- send while busy=1 is ignored; it is neither queued nor able to corrupt the frame. Changes to data_in after accept have no effect.
- The baud counter is local. It reloads at every state entry, so bit timing is exact with no drift across bytes.
- byte_cnt width is clog2(NUM_BYTES). bit_cnt is 3 bits. The baud counter width is clog2(CLKS_PER_BIT).

## Timing
- Reset values: TxD=1, busy=0, done=0, state=IDLE, all counters 0.
- rst wins over every other event. Reset mid-frame drives TxD=1 from the next cycle, clears busy, and suppresses done. A truncated frame on the line is acceptable.
- TxD, busy and done are registered outputs.
- If accept occurs in cycle N:
  - TxD falls and busy rises at cycle N+1.
  - Bit k of the message occupies cycles N+1+k*CLKS_PER_BIT through N+(k+1)*CLKS_PER_BIT.
- done=1 and busy=0 appear in cycle N+1+NUM_BYTES*10*CLKS_PER_BIT.
- The done cycle is in IDLE, so a send in that cycle is accepted. The next start bit then begins the following cycle, back-to-back.

## Structure
- Shared package uart_pkg holds:
  - the clks_per_bit(CLK_FREQ, BAUD) function, also reused by the receiver;
  - the UART bit-state enum (IDLE, START, DATA, STOP);
  - the frame constants (8 data bits, 1 stop bit).
- Sub-module uart_byte_tx frames one byte with a valid/ready handshake and owns the baud counter, bit_cnt and TxD.
- digest_uart_tx owns the shift register, byte_cnt, and the busy/done sequencing.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD=250_000, so CLKS_PER_BIT=4.
- **Reset:** hold rst 3 cycles with send=1 -> TxD=1, busy=0, done=0 throughout; no frame starts.
- **Two-byte frame:** NUM_BYTES=2, data_in=16'hA55A, send in cycle 0 -> TxD bit sequence 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1, each bit 4 cycles; done=1 in cycle 81 only; busy=1 cycles 1–80.
- **Send while busy:** repeat the two-byte frame, changing data_in to 16'hFFFF and pulsing send at cycle 20 -> line output is identical to the two-byte frame; exactly one done pulse.
- **Reset mid-frame:** rst at cycle 30 of a transfer -> TxD=1 and busy=0 from cycle 31; no done. A new send at cycle 40 transmits cleanly from its own start bit.
- **Back-to-back:** send asserted in the done cycle with 16'h1234 -> start bit at the next cycle; bench UART model decodes 0x12, 0x34.
- **Full 32-byte message:** default NUM_BYTES, data_in = bytes 0x00..0x1F MSB-first -> bench UART model receives 0x00,0x01,...,0x1F in order; done at cycle 1+32*40=1281.
